fetch_stage: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the 8-bit pipeline register.
- Generates sequential program-counter addresses and issues reads to the instruction memory, which has a fixed 1-cycle latency.
- Buffers returned instructions in a 2-entry FIFO.
- Presents instruction/PC pairs to the pipeline register over a valid/ready handshake.
- Supports single-cycle branch redirect with flush.

---
 rtl/fetch_if.sv | 40 ++++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory read port, branch redirect
// and the valid/ready instruction handshake toward the pipeline register.
interface fetch_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_target;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] pc_out;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  branch_valid,
        input  branch_target,
        output instr_valid,
        input  instr_ready,
        output instr_out,
        output pc_out
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output branch_valid,
        output branch_target,
        input  instr_valid,
        output instr_ready,
        input  instr_out,
        input  pc_out
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: sequential PC, 1-cycle imem reads, 2-entry
// instruction FIFO and single-cycle branch redirect with flush.
module fetch_stage #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic      clk,
    input logic      rst_n,
    fetch_if.master  bus
);
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_addr_q;
    logic [DATA_W-1:0] data_q [2];
    logic [ADDR_W-1:0] addr_q [2];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        count_q, count_d;

    logic req, push, pop, flush;

    assign flush = bus.branch_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Pops in the same cycle do not free a slot for a new request
    always_comb begin
        req = (state_q == RUN) && !flush &&
              (({1'b0, count_q} + {2'b0, inflight_q}) < 3'd2);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (flush) begin
            fetch_pc_d = bus.branch_target;
        end else if (req) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
        end
    end

    assign push = inflight_q && !flush;
    assign pop  = bus.instr_valid && bus.instr_ready;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= BOOT;
            fetch_pc_q      <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= req;
            count_q    <= count_d;
            if (req) begin
                inflight_addr_q <= fetch_pc_q;
            end
            if (flush) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                if (push) begin
                    wr_ptr_q         <= ~wr_ptr_q;
                    data_q[wr_ptr_q] <= bus.imem_rdata;
                    addr_q[wr_ptr_q] <= inflight_addr_q;
                end
            end
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = (count_q != 2'd0) && !flush;
    assign bus.instr_out   = data_q[rd_ptr_q];
    assign bus.pc_out      = addr_q[rd_ptr_q];
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: reference model of requests,
// FIFO contents and branch flush; second instance checks PC wrap.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    fetch_if #(.ADDR_W(8), .DATA_W(8)) wbus ();

    fetch_stage #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_stage #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'hFE)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbus)
    );

    // 1-cycle memories returning addr ^ A5
    always @(posedge clk) bus.imem_rdata <= bus.imem_addr ^ 8'hA5;
    always @(posedge clk) wbus.imem_rdata <= wbus.imem_addr ^ 8'hA5;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_pc;
    logic [7:0] m_pend;
    logic       m_inf;
    logic       m_run;
    logic       cnt_ok = 1'b1;
    logic       wrap_done = 1'b0;

    task automatic model_reset();
        q.delete();
        m_pc   = 8'h00;
        m_pend = 8'h00;
        m_inf  = 1'b0;
        m_run  = 1'b0;
    endtask

    task automatic eval(input logic rdy);
        logic ereq, evld;
        logic [7:0] h;
        ereq = m_run && !bus.branch_valid && ((q.size() + int'(m_inf)) < 2);
        chk("req", 32'(bus.imem_req), 32'(ereq));
        if (ereq) chk("addr", 32'(bus.imem_addr), 32'(m_pc));
        evld = (q.size() != 0) && !bus.branch_valid;
        chk("valid", 32'(bus.instr_valid), 32'(evld));
        if (evld) begin
            h = q[0];
            chk("pc_out", 32'(bus.pc_out), 32'(h));
            chk("instr_out", 32'(bus.instr_out), 32'(h ^ 8'hA5));
        end
        if (dut.count_q > 2'd2) cnt_ok = 1'b0;
        if (bus.branch_valid) begin
            q.delete();
            m_inf = 1'b0;
            m_pc  = bus.branch_target;
        end else begin
            if (evld && rdy) void'(q.pop_front());
            if (m_inf) q.push_back(m_pend);
            m_inf  = ereq;
            m_pend = m_pc;
            if (ereq) m_pc = m_pc + 8'd1;
        end
        m_run = 1'b1;
    endtask

    task automatic cyc(input logic bv, input logic [7:0] bt, input logic rdy);
        @(negedge clk);
        rst_n             = 1'b1;
        bus.branch_valid  = bv;
        bus.branch_target = bt;
        bus.instr_ready   = rdy;
        #2;
        eval(rdy);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req"}, 32'(bus.imem_req), 32'd0);
        chk({tag, "_vld"}, 32'(bus.instr_valid), 32'd0);
        chk({tag, "_ins"}, 32'(bus.instr_out), 32'd0);
        chk({tag, "_pc"}, 32'(bus.pc_out), 32'd0);
    endtask

    initial begin : wrap_chk
        logic [7:0] exp_w;
        int got;
        exp_w = 8'hFE;
        got   = 0;
        wbus.instr_ready   = 1'b1;
        wbus.branch_valid  = 1'b0;
        wbus.branch_target = 8'h00;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            #3;
            if (wbus.instr_valid) begin
                chk("wrap_pc", 32'(wbus.pc_out), 32'(exp_w));
                chk("wrap_ins", 32'(wbus.instr_out), 32'(exp_w ^ 8'hA5));
                exp_w = exp_w + 8'd1;
                got++;
            end
        end
        chk("wrap_cnt", 32'(got), 32'd4);
        wrap_done = 1'b1;
    end

    initial begin
        rst_n             = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 8'h00;
        bus.instr_ready   = 1'b1;
        model_reset();
        #7;
        chk_reset_outs("rst0");

        // Streaming from reset with ready held high
        for (int i = 0; i < 14; i++) cyc(1'b0, 8'h00, 1'b1);

        // Backpressure: fill, hold, then drain
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1);

        // Branch with a full FIFO
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h40, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);

        // Branch with a read in flight, then back-to-back branches
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h60, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h80, 1'b1);
        cyc(1'b1, 8'h90, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);

        // Random ready and branches
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom % 16) == 0, 8'($urandom_range(0, 255)),
                ($urandom % 4) != 0);
        end

        // Asynchronous reset mid-stream with a full FIFO
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0);
        chk("full_before_rst", 32'(q.size()), 32'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst1");
        model_reset();
        for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);

        // Branch during BOOT loads the PC and BOOT still completes
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        cyc(1'b1, 8'h20, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);

        chk("cnt_le2", 32'(cnt_ok), 32'd1);
        chk("wrap_done", 32'(wrap_done), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
